// File: rtl/xbus_arbiter.sv
// xbus_arbiter: two-master round-robin arbiter for the shared xbus.
// Every transfer runs IDLE -> ACCESS (strobe, slaves sample) -> RESP (ack +
// read data to the winner). Back-to-back transfers skip IDLE.
// Optional feature: define XBUS_ARB_LOCK_EN to add m0_lock/m1_lock, which let
// the master just served in RESP keep the bus for an atomic sequence.
module xbus_arbiter #(
  parameter int ADDRW = 32,
  parameter int DATAW = 32,
  parameter int BYTEC = 4
) (
  input  logic             clk,
  input  logic             rst,
  // master 0 (core)
  input  logic             m0_req,
  input  logic             m0_we,
  input  logic [BYTEC-1:0] m0_be,
  input  logic [ADDRW-1:0] m0_addr,
  input  logic [DATAW-1:0] m0_wdata,
  output logic             m0_ack,
  output logic [DATAW-1:0] m0_rdata,
  // master 1 (DMA / boot loader)
  input  logic             m1_req,
  input  logic             m1_we,
  input  logic [BYTEC-1:0] m1_be,
  input  logic [ADDRW-1:0] m1_addr,
  input  logic [DATAW-1:0] m1_wdata,
  output logic             m1_ack,
  output logic [DATAW-1:0] m1_rdata,
`ifdef XBUS_ARB_LOCK_EN
  input  logic             m0_lock,
  input  logic             m1_lock,
`endif
  // shared bus toward decoder and slaves
  output logic             xbus_as,
  output logic             xbus_we,
  output logic [BYTEC-1:0] xbus_be,
  output logic [ADDRW-1:0] xbus_addr,
  output logic [DATAW-1:0] xbus_wdata,
  input  logic [DATAW-1:0] xbus_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0] state_reg, state_next;
  logic       gnt_reg, gnt_next;
  logic       last_reg, last_next;

  // Per-master views so the muxing below is indexed by the grant.
  logic [1:0]       req_vec;
  logic [1:0]       we_vec;
  logic [BYTEC-1:0] be_arr    [2];
  logic [ADDRW-1:0] addr_arr  [2];
  logic [DATAW-1:0] wdata_arr [2];
  logic [1:0]       ack_vec;
  logic [DATAW-1:0] rdata_arr [2];

  assign req_vec      = {m1_req, m0_req};
  assign we_vec       = {m1_we, m0_we};
  assign be_arr[0]    = m0_be;
  assign be_arr[1]    = m1_be;
  assign addr_arr[0]  = m0_addr;
  assign addr_arr[1]  = m1_addr;
  assign wdata_arr[0] = m0_wdata;
  assign wdata_arr[1] = m1_wdata;

  // Re-grant the master just served when it asks to keep the bus locked.
  logic lock_hold;
`ifdef XBUS_ARB_LOCK_EN
  logic [1:0] lock_vec;
  assign lock_vec  = {m1_lock, m0_lock};
  assign lock_hold = lock_vec[gnt_reg] & req_vec[gnt_reg];
`else
  assign lock_hold = 1'b0;
`endif

  // Round-robin pick: a lone requester wins, contention goes to the master
  // that was not served most recently. Only called with at least one req.
  function automatic logic rr_pick(input logic [1:0] req, input logic prev);
    if (req[0] && req[1]) begin
      return ~prev;
    end else if (req[1]) begin
      return 1'b1;
    end else begin
      return 1'b0;
    end
  endfunction

  // Reset aborts a transfer immediately: strobe and ack are masked in the
  // reset cycle itself, not just from the following one.
  logic access_live;
  logic resp_live;
  assign access_live = (state_reg == ACCESS) && !rst;
  assign resp_live   = (state_reg == RESP) && !rst;

  // Next-state, grant and history. In RESP the master being acked becomes
  // "last" at this same edge, so it is the reference for the new pick.
  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    last_next  = last_reg;
    case (state_reg)
      IDLE: begin
        if (|req_vec) begin
          state_next = ACCESS;
          gnt_next   = rr_pick(req_vec, last_reg);
        end
      end
      ACCESS: begin
        state_next = RESP;
      end
      RESP: begin
        last_next = gnt_reg;
        if (|req_vec) begin
          state_next = ACCESS;
          gnt_next   = lock_hold ? gnt_reg : rr_pick(req_vec, gnt_reg);
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State registers; last=1 after reset so master 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      gnt_reg   <= 1'b0;
      last_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      last_reg  <= last_next;
    end
  end

  // Bus drive: granted master's request, only while strobing.
  always_comb begin
    xbus_as    = access_live;
    xbus_we    = 1'b0;
    xbus_be    = '0;
    xbus_addr  = '0;
    xbus_wdata = '0;
    if (access_live) begin
      xbus_we    = we_vec[gnt_reg];
      xbus_be    = be_arr[gnt_reg];
      xbus_addr  = addr_arr[gnt_reg];
      xbus_wdata = wdata_arr[gnt_reg];
    end
  end

  // Ack and read data return, one lane per master.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ret
      assign ack_vec[gi]   = resp_live && (gnt_reg == 1'(gi));
      assign rdata_arr[gi] = ack_vec[gi] ? xbus_rdata : '0;
    end
  endgenerate

  assign m0_ack   = ack_vec[0];
  assign m1_ack   = ack_vec[1];
  assign m0_rdata = rdata_arr[0];
  assign m1_rdata = rdata_arr[1];

endmodule

// File: tb/tb_xbus_arbiter.sv
// Directed, cycle-by-cycle vector bench for xbus_arbiter. Each record holds
// one cycle of inputs and the hand-computed outputs for that cycle.
module tb_xbus_arbiter;

`ifdef XBUS_ARB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [3:0]  m0_be = '0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic        m0_ack;
  logic [31:0] m0_rdata;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [3:0]  m1_be = '0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic        m1_ack;
  logic [31:0] m1_rdata;
`ifdef XBUS_ARB_LOCK_EN
  logic        m0_lock = 1'b0, m1_lock = 1'b0;
`endif
  logic        xbus_as, xbus_we;
  logic [3:0]  xbus_be;
  logic [31:0] xbus_addr, xbus_wdata;
  logic [31:0] xbus_rdata = '0;

  xbus_arbiter #(.ADDRW(32), .DATAW(32), .BYTEC(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
`ifdef XBUS_ARB_LOCK_EN
    .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
    .xbus_as(xbus_as), .xbus_we(xbus_we), .xbus_be(xbus_be),
    .xbus_addr(xbus_addr), .xbus_wdata(xbus_wdata), .xbus_rdata(xbus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        r0, we0;
    logic [3:0]  be0;
    logic [31:0] a0, d0;
    logic        r1, we1;
    logic [3:0]  be1;
    logic [31:0] a1, d1;
    logic        lk1;
    logic [31:0] rdata;
    logic [135:0] exp;
  } vec_t;

  vec_t vq[$];
  int   applied = 0;
  int   miscompares = 0;

  // expected {as, we, be, addr, wdata, ack0, rdata0, ack1, rdata1}
  localparam logic [135:0] E0 = '0;
  function automatic logic [135:0] e_acc(input logic we, input logic [3:0] be,
                                         input logic [31:0] addr, input logic [31:0] wd);
    return {1'b1, we, be, addr, wd, 1'b0, 32'h0, 1'b0, 32'h0};
  endfunction
  function automatic logic [135:0] e_ack(input logic m, input logic [31:0] rd);
    if (m) return {70'h0, 1'b0, 32'h0, 1'b1, rd};
    else   return {70'h0, 1'b1, rd, 1'b0, 32'h0};
  endfunction

  function automatic vec_t mk(input string name, input logic rs,
                              input logic r0, input logic we0, input logic [3:0] be0,
                              input logic [31:0] a0, input logic [31:0] d0,
                              input logic r1, input logic we1, input logic [3:0] be1,
                              input logic [31:0] a1, input logic [31:0] d1,
                              input logic lk1, input logic [31:0] rdata,
                              input logic [135:0] exp);
    vec_t v;
    v.name = name; v.rst = rs;
    v.r0 = r0; v.we0 = we0; v.be0 = be0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.we1 = we1; v.be1 = be1; v.a1 = a1; v.d1 = d1;
    v.lk1 = lk1; v.rdata = rdata; v.exp = exp;
    return v;
  endfunction

  task automatic step(input vec_t v);
    logic [135:0] act;
    @(negedge clk);
    rst = v.rst;
    m0_req = v.r0; m0_we = v.we0; m0_be = v.be0; m0_addr = v.a0; m0_wdata = v.d0;
    m1_req = v.r1; m1_we = v.we1; m1_be = v.be1; m1_addr = v.a1; m1_wdata = v.d1;
`ifdef XBUS_ARB_LOCK_EN
    m0_lock = 1'b0; m1_lock = v.lk1;
`endif
    xbus_rdata = v.rdata;
    #1;
    act = {xbus_as, xbus_we, xbus_be, xbus_addr, xbus_wdata, m0_ack, m0_rdata, m1_ack, m1_rdata};
    applied++;
    if (act !== v.exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", v.name, act, v.exp);
    end else begin
      $display("ok   %s: %h", v.name, act);
    end
  endtask

  initial begin
    // reset and single read by m0
    vq.push_back(mk("rst_a",   1, 0,0,4'h0,32'h0,32'h0,     0,0,4'h0,32'h0,32'h0, 0, 32'h0, E0));
    vq.push_back(mk("rst_b",   1, 0,0,4'h0,32'h0,32'h0,     0,0,4'h0,32'h0,32'h0, 0, 32'h0, E0));
    vq.push_back(mk("idle0",   0, 0,0,4'h0,32'h0,32'h0,     0,0,4'h0,32'h0,32'h0, 0, 32'h0, E0));
    vq.push_back(mk("rd_req",  0, 1,0,4'hF,32'h1000,32'h0,  0,0,4'h0,32'h0,32'h0, 0, 32'h0, E0));
    vq.push_back(mk("rd_acc",  0, 1,0,4'hF,32'h1000,32'h0,  0,0,4'h0,32'h0,32'h0, 0, 32'h0,
                    e_acc(0, 4'hF, 32'h1000, 32'h0)));
    vq.push_back(mk("rd_ack",  0, 0,0,4'hF,32'h1000,32'h0,  0,0,4'h0,32'h0,32'h0, 0, 32'hDEADBEEF,
                    e_ack(0, 32'hDEADBEEF)));
    // single write by m1
    vq.push_back(mk("wr_req",  0, 0,0,4'h0,32'h0,32'h0,     1,1,4'h3,32'h2004,32'h1234, 0, 32'h0, E0));
    vq.push_back(mk("wr_acc",  0, 0,0,4'h0,32'h0,32'h0,     1,1,4'h3,32'h2004,32'h1234, 0, 32'h0,
                    e_acc(1, 4'h3, 32'h2004, 32'h1234)));
    vq.push_back(mk("wr_ack",  0, 0,0,4'h0,32'h0,32'h0,     0,1,4'h3,32'h2004,32'h1234, 0, 32'h0,
                    e_ack(1, 32'h0)));
    // idle gap: no spurious strobes or acks
    vq.push_back(mk("gap1",    0, 0,0,4'h0,32'h0,32'h0,     0,0,4'h0,32'h0,32'h0, 0, 32'h0, E0));
    vq.push_back(mk("gap2",    0, 0,0,4'h0,32'h0,32'h0,     0,0,4'h0,32'h0,32'h0, 0, 32'h0, E0));
    vq.push_back(mk("gap3",    0, 0,0,4'h0,32'h0,32'h0,     0,0,4'h0,32'h0,32'h0, 0, 32'h0, E0));
    // contention from reset: 0,1,0,1 back to back
    vq.push_back(mk("c_rst",   1, 0,0,4'h0,32'h0,32'h0,     0,0,4'h0,32'h0,32'h0, 0, 32'h0, E0));
    vq.push_back(mk("c_idle",  0, 0,0,4'h0,32'h0,32'h0,     0,0,4'h0,32'h0,32'h0, 0, 32'h0, E0));
    vq.push_back(mk("c_req",   0, 1,0,4'hF,32'h100,32'h0,   1,0,4'hF,32'h200,32'h0, 0, 32'h0, E0));
    vq.push_back(mk("c_acc0",  0, 1,0,4'hF,32'h100,32'h0,   1,0,4'hF,32'h200,32'h0, 0, 32'h0,
                    e_acc(0, 4'hF, 32'h100, 32'h0)));
    vq.push_back(mk("c_ack0",  0, 1,0,4'hF,32'h100,32'h0,   1,0,4'hF,32'h200,32'h0, 0, 32'hA0,
                    e_ack(0, 32'hA0)));
    vq.push_back(mk("c_acc1",  0, 1,0,4'hF,32'h100,32'h0,   1,0,4'hF,32'h200,32'h0, 0, 32'h0,
                    e_acc(0, 4'hF, 32'h200, 32'h0)));
    vq.push_back(mk("c_ack1",  0, 1,0,4'hF,32'h100,32'h0,   1,0,4'hF,32'h200,32'h0, 0, 32'hB1,
                    e_ack(1, 32'hB1)));
    vq.push_back(mk("c_acc2",  0, 1,0,4'hF,32'h100,32'h0,   1,0,4'hF,32'h200,32'h0, 0, 32'h0,
                    e_acc(0, 4'hF, 32'h100, 32'h0)));
    vq.push_back(mk("c_ack2",  0, 1,0,4'hF,32'h100,32'h0,   1,0,4'hF,32'h200,32'h0, 0, 32'hC2,
                    e_ack(0, 32'hC2)));
    vq.push_back(mk("c_acc3",  0, 1,0,4'hF,32'h100,32'h0,   1,0,4'hF,32'h200,32'h0, 0, 32'h0,
                    e_acc(0, 4'hF, 32'h200, 32'h0)));
    vq.push_back(mk("c_ack3",  0, 0,0,4'hF,32'h100,32'h0,   0,0,4'hF,32'h200,32'h0, 0, 32'hD3,
                    e_ack(1, 32'hD3)));
    vq.push_back(mk("c_idle2", 0, 0,0,4'h0,32'h0,32'h0,     0,0,4'h0,32'h0,32'h0, 0, 32'h0, E0));

    for (int i = 0; i < vq.size(); i++) step(vq[i]);

    // Reset mid-transfer. First serve m0 so last=0; reset must restore last=1,
    // which is what makes the following contention go to m0 again.
    step(mk("p_req",   0, 1,0,4'hF,32'h300,32'h0,   0,0,4'h0,32'h0,32'h0, 0, 32'h0, E0));
    step(mk("p_acc",   0, 1,0,4'hF,32'h300,32'h0,   0,0,4'h0,32'h0,32'h0, 0, 32'h0,
            e_acc(0, 4'hF, 32'h300, 32'h0)));
    step(mk("p_ack",   0, 0,0,4'hF,32'h300,32'h0,   0,0,4'h0,32'h0,32'h0, 0, 32'h22, e_ack(0, 32'h22)));
    step(mk("r_req",   0, 1,0,4'hF,32'h310,32'h0,   0,0,4'h0,32'h0,32'h0, 0, 32'h0, E0));
    step(mk("r_rstacc",1, 1,0,4'hF,32'h310,32'h0,   0,0,4'h0,32'h0,32'h0, 0, 32'h0, E0));
    step(mk("r_noack", 0, 0,0,4'h0,32'h0,32'h0,     0,0,4'h0,32'h0,32'h0, 0, 32'h77, E0));
    step(mk("r_idle",  0, 0,0,4'h0,32'h0,32'h0,     0,0,4'h0,32'h0,32'h0, 0, 32'h0, E0));
    step(mk("r_creq",  0, 1,0,4'hF,32'h400,32'h0,   1,0,4'hF,32'h500,32'h0, 0, 32'h0, E0));
    step(mk("r_cacc",  0, 1,0,4'hF,32'h400,32'h0,   1,0,4'hF,32'h500,32'h0, 0, 32'h0,
            e_acc(0, 4'hF, 32'h400, 32'h0)));
    step(mk("r_cack",  0, 0,0,4'hF,32'h400,32'h0,   0,0,4'hF,32'h500,32'h0, 0, 32'h11, e_ack(0, 32'h11)));
    step(mk("r_idle2", 0, 0,0,4'h0,32'h0,32'h0,     0,0,4'h0,32'h0,32'h0, 0, 32'h0, E0));

    // m1 holds lock for two transfers while m0 waits: locked build serves
    // m1,m1,m0; plain round-robin serves m1,m0,m1.
    step(mk("l_req",   0, 0,0,4'h0,32'h0,32'h0,     1,0,4'hF,32'h600,32'h0, 1, 32'h0, E0));
    step(mk("l_acc1",  0, 1,0,4'hF,32'h700,32'h0,   1,0,4'hF,32'h600,32'h0, 1, 32'h0,
            e_acc(0, 4'hF, 32'h600, 32'h0)));
    step(mk("l_ack1",  0, 1,0,4'hF,32'h700,32'h0,   1,0,4'hF,32'h600,32'h0, 1, 32'h61, e_ack(1, 32'h61)));
    step(mk("l_acc2",  0, 1,0,4'hF,32'h700,32'h0,   1,0,4'hF,32'h600,32'h0, 1, 32'h0,
            e_acc(0, 4'hF, LOCK ? 32'h600 : 32'h700, 32'h0)));
    step(mk("l_ack2",  0, 1,0,4'hF,32'h700,32'h0,   1,0,4'hF,32'h600,32'h0, 0, 32'h62,
            e_ack(LOCK ? 1'b1 : 1'b0, 32'h62)));
    step(mk("l_acc3",  0, 1,0,4'hF,32'h700,32'h0,   1,0,4'hF,32'h600,32'h0, 0, 32'h0,
            e_acc(0, 4'hF, LOCK ? 32'h700 : 32'h600, 32'h0)));
    step(mk("l_ack3",  0, 0,0,4'hF,32'h700,32'h0,   0,0,4'hF,32'h600,32'h0, 0, 32'h63,
            e_ack(LOCK ? 1'b0 : 1'b1, 32'h63)));
    step(mk("l_idle",  0, 0,0,4'h0,32'h0,32'h0,     0,0,4'h0,32'h0,32'h0, 0, 32'h0, E0));

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/xbus_arbiter.md
Name: xbus_arbiter

Overview:
- Two-master arbiter for the shared xbus: master 0 is the core data/instruction port; master 1 is a second bus master (DMA / UART boot loader).
- Sequences every bus access through a fixed ACCESS→RESP pipeline and drives the single xbus_as/we/be/addr/wdata set into xbus_decoder and the slaves.
- Returns xbus_rdata and a one-cycle ack to the winning master.
- Round-robin fairness under contention.

Parameters:
- ADDRW, 32, xbus address width
- DATAW, 32, xbus data width
- BYTEC, 4, byte-enable width (DATAW/8)

Ports:
- clk  in  1  bus clock (same clock as slaves)
- rst  in  1  synchronous reset, active-high
- m0_req  in  1  master 0 request; held until m0_ack
- m0_we  in  1  master 0 write enable
- m0_be  in  BYTEC  master 0 byte enables
- m0_addr  in  ADDRW  master 0 address
- m0_wdata  in  DATAW  master 0 write data
- m0_ack  out  1  master 0 transfer complete, one-cycle pulse
- m0_rdata  out  DATAW  master 0 read data, valid while m0_ack=1
- m1_req, m1_we, m1_be, m1_addr, m1_wdata, m1_ack, m1_rdata: same as m0_* for master 1
- xbus_as  out  1  address strobe to decoder/slaves
- xbus_we  out  1  bus write enable
- xbus_be  out  BYTEC  bus byte enables
- xbus_addr  out  ADDRW  bus address
- xbus_wdata  out  DATAW  bus write data
- xbus_rdata  in  DATAW  OR-muxed slave read data, valid one cycle after the strobe

Behaviour:
- One clock (clk), synchronous active-high reset rst.
- State register values: IDLE, ACCESS, RESP. Registered gnt (0/1) selects the granted master; registered last (0/1) holds the last served master.
- Reset values: state=IDLE, gnt=0, last=1 (master 0 wins the first contention). All outputs 0: xbus_as=0, m0_ack=m1_ack=0; xbus_* and m*_rdata are 0 or don't-care while not strobed/acked.
- Arbitration happens at the clock edge ending IDLE, or ending RESP when a request is pending:
  - Only one req: grant it.
  - Both reqs: grant the master != last.
- IDLE: xbus_as=0. If any req, go to ACCESS with gnt set; otherwise stay.
- ACCESS, exactly one cycle:
  - xbus_as=1.
  - xbus_we/be/addr/wdata combinationally muxed from the granted master's inputs.
  - Slaves sample at the end of this cycle. Go to RESP.
- RESP, exactly one cycle:
  - xbus_as=0.
  - m{gnt}_ack=1.
  - m{gnt}_rdata = xbus_rdata (combinational pass-through); the other master's ack=0.
  - last<=gnt.
  - Next state: ACCESS (back-to-back, new arbitration) if any req is asserted, otherwise IDLE.
- A master's req seen during RESP for its own completed transfer counts as a new request. Masters must drop req in the ack cycle if they have no further access.
- Latency: req rising in IDLE cycle t → xbus_as in t+1 → ack in t+2. Back-to-back throughput is one transfer per 2 cycles.
- Writes also complete with ack in RESP; rdata is don't-care for writes.
- Masters hold all request signals stable from req until ack. Arbiter behaviour is undefined if a master changes them.
- Requests are never dropped: a waiting master is served at most one transfer later (round-robin bound).
- Reset during ACCESS or RESP: next cycle IDLE. No ack is issued for the aborted transfer; xbus_as deasserts immediately.
- Never grants a master whose req=0.

Optional Feature:
- Macro XBUS_ARB_LOCK_EN.
- When defined:
  - Extra inputs m0_lock and m1_lock (1 bit each).
  - If the master granted in RESP has lock=1 and req=1, it is re-granted regardless of last, giving atomic read-modify-write sequences.
  - Lock is ignored in IDLE arbitration.
- When undefined: lock ports are absent and pure round-robin applies.

Test Plan:
- Single read: m0_req=1, addr=0x1000, we=0, slave returns 0xDEADBEEF → xbus_as=1 in cycle 1, m0_ack=1 with m0_rdata=0xDEADBEEF in cycle 2, m1_ack stays 0.
- Single write: m1 write, addr=0x2004, be=4'b0011, wdata=0x1234 → xbus_we=1, be=0011, addr=0x2004 during xbus_as; m1_ack in the next cycle.
- Contention from reset: m0 and m1 req in the same cycle → m0 served first; m1 ACCESS directly after m0's RESP with no IDLE. Grant order 0,1,0,1 over 4 transfers if both keep requesting.
- Idle gap: req drops in the ack cycle → state IDLE, xbus_as=0, no spurious ack for ≥3 cycles.
- Reset mid-transfer: rst=1 during ACCESS → no ack, xbus_as=0 the next cycle. After release, the next contention grants m0.
- With XBUS_ARB_LOCK_EN: m1 holds lock=1 for 2 transfers while m0 requests → m1,m1 then m0. Without the macro → m1,m0 alternation.
